// File: rtl/march_elem_seq_pkg.sv
// Shared PMBIST types and widths for the march element sequencer and its
// address stepper.
package march_elem_seq_pkg;

  localparam int ADDR_X     = 4;
  localparam int ADDR_Y     = 4;
  localparam int ADDR_X_MAX = (1 << ADDR_X) - 1;
  localparam int ADDR_Y_MAX = (1 << ADDR_Y) - 1;
  localparam int BG_DATA    = 8;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_RMW   = 2'd3
  } t_op_cmd;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } t_mes_state;

  // Data issued for one op slot: inverted or true background.
  function automatic logic [BG_DATA-1:0] slot_data(input logic inv,
                                                   input logic [BG_DATA-1:0] bg);
    return inv ? ~bg : bg;
  endfunction

endpackage

// File: rtl/march_elem_seq_addr_stepper.sv
// X/Y address walker for one march element: direction, fast axis, wrap and
// last-address detection. Configuration is captured on load.
module addr_stepper
  import march_elem_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_down,
  input  logic              i_x_fast,
  input  logic [ADDR_X-1:0] i_x_max,
  input  logic [ADDR_Y-1:0] i_y_max,
  output logic [ADDR_X-1:0] o_x,
  output logic [ADDR_Y-1:0] o_y,
  output logic              o_is_last
);

  logic [ADDR_X-1:0] x_q, x_max_q, x_nxt, x_lim, x_start, x_adv;
  logic [ADDR_Y-1:0] y_q, y_max_q, y_nxt, y_lim, y_start, y_adv;
  logic              down_q, x_fast_q;
  logic              x_wrap, y_wrap;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    x_lim   = down_q ? '0 : x_max_q;
    y_lim   = down_q ? '0 : y_max_q;
    x_start = down_q ? x_max_q : '0;
    y_start = down_q ? y_max_q : '0;
    x_adv   = down_q ? x_q - 1'b1 : x_q + 1'b1;
    y_adv   = down_q ? y_q - 1'b1 : y_q + 1'b1;
    x_wrap  = (x_q == x_lim);
    y_wrap  = (y_q == y_lim);
    x_nxt   = x_q;
    y_nxt   = y_q;
    if (x_fast_q) begin
      x_nxt = x_wrap ? x_start : x_adv;
      if (x_wrap) y_nxt = y_wrap ? y_start : y_adv;
    end else begin
      y_nxt = y_wrap ? y_start : y_adv;
      if (y_wrap) x_nxt = x_wrap ? x_start : x_adv;
    end
  end

  // Both coordinates sitting at their end limit is exactly the final address.
  assign o_is_last = x_wrap && y_wrap;
  assign o_x       = x_q;
  assign o_y       = y_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q      <= '0;
      y_q      <= '0;
      x_max_q  <= '0;
      y_max_q  <= '0;
      down_q   <= 1'b0;
      x_fast_q <= 1'b0;
    end else if (i_load) begin
      x_q      <= i_down ? i_x_max : '0;
      y_q      <= i_down ? i_y_max : '0;
      x_max_q  <= i_x_max;
      y_max_q  <= i_y_max;
      down_q   <= i_down;
      x_fast_q <= i_x_fast;
    end else if (i_step) begin
      x_q <= x_nxt;
      y_q <= y_nxt;
    end
  end

endmodule

// File: rtl/march_elem_seq.sv
// March element sequencer: walks the address space and issues the programmed
// op list at every address, with hold/pause support and a done pulse.
module march_elem_seq
  import march_elem_seq_pkg::*;
#(
  parameter int MAX_OPS = 4,
  parameter int OPC_W   = $clog2(MAX_OPS + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_start,
  input  logic               i_hold,
  input  logic [OPC_W-1:0]   i_num_ops,
  input  t_op_cmd            i_op_list [MAX_OPS],
  input  logic [MAX_OPS-1:0] i_op_inv,
  input  logic               i_addr_down,
  input  logic               i_x_fast,
  input  logic [ADDR_X-1:0]  i_addr_x_max,
  input  logic [ADDR_Y-1:0]  i_addr_y_max,
  input  logic [BG_DATA-1:0] i_bg_data,
  output t_op_cmd            o_op_cmd,
  output logic [ADDR_X-1:0]  o_addr_x,
  output logic [ADDR_Y-1:0]  o_addr_y,
  output logic [BG_DATA-1:0] o_data,
  output logic               o_busy,
  output logic               o_done
);

  localparam int IDX_W = (MAX_OPS > 1) ? $clog2(MAX_OPS) : 1;

  t_mes_state         state_q, state_nxt;
  t_op_cmd            op_list_q [MAX_OPS];
  logic [MAX_OPS-1:0] op_inv_q;
  logic [BG_DATA-1:0] bg_q;
  logic [IDX_W-1:0]   op_idx_q, op_last_q, num_last;
  logic               start_ok, issue, idx_wrap, addr_last, finish;
  logic [ADDR_X-1:0]  cur_x;
  logic [ADDR_Y-1:0]  cur_y;

  addr_stepper u_addr_stepper (
    .clk       (clk),
    .rstn      (rstn),
    .i_load    (start_ok),
    .i_step    (issue && idx_wrap),
    .i_down    (i_addr_down),
    .i_x_fast  (i_x_fast),
    .i_x_max   (i_addr_x_max),
    .i_y_max   (i_addr_y_max),
    .o_x       (cur_x),
    .o_y       (cur_y),
    .o_is_last (addr_last)
  );

  always_comb begin
    // Last op index of the element: 0 ops behaves as 1, excess clamps.
    if (i_num_ops == '0)                       num_last = '0;
    else if (i_num_ops > OPC_W'(MAX_OPS))      num_last = IDX_W'(MAX_OPS - 1);
    else                                       num_last = IDX_W'(i_num_ops - 1'b1);

    start_ok  = (state_q == IDLE) && i_start;
    issue     = (state_q == RUN) && !i_hold;
    idx_wrap  = (op_idx_q == op_last_q);
    finish    = issue && idx_wrap && addr_last;

    state_nxt = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (finish)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // Element configuration is captured only on an accepted start, so input
  // changes while running have no effect.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_list_q <= '{default: OP_NOP};
      op_inv_q  <= '0;
      bg_q      <= '0;
      op_last_q <= '0;
      op_idx_q  <= '0;
    end else if (start_ok) begin
      op_list_q <= i_op_list;
      op_inv_q  <= i_op_inv;
      bg_q      <= i_bg_data;
      op_last_q <= num_last;
      op_idx_q  <= '0;
    end else if (issue) begin
      op_idx_q  <= idx_wrap ? '0 : op_idx_q + 1'b1;
    end
  end

  // Outputs are registered; busy/done therefore trail the FSM by one cycle,
  // which lines done up with the cycle after the final issued op.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_op_cmd <= OP_NOP;
      o_addr_x <= '0;
      o_addr_y <= '0;
      o_data   <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_op_cmd <= issue ? op_list_q[op_idx_q] : OP_NOP;
      if (issue) begin
        o_addr_x <= cur_x;
        o_addr_y <= cur_y;
        o_data   <= slot_data(op_inv_q[op_idx_q], bg_q);
      end
      o_busy <= (state_q != IDLE);
      o_done <= (state_q == DONE);
    end
  end

endmodule

// File: tb/tb_march_elem_seq.sv
// Self-checking bench for march_elem_seq: directed vector table, hold/abort
// sequences and randomized elements against a loop-nest reference model.
module tb_march_elem_seq;
  import march_elem_seq_pkg::*;

  localparam int MAX_OPS = 4;
  localparam int OPC_W   = $clog2(MAX_OPS + 1);

  logic               clk, rstn, i_start, i_hold;
  logic [OPC_W-1:0]   i_num_ops;
  t_op_cmd            i_op_list [MAX_OPS];
  logic [MAX_OPS-1:0] i_op_inv;
  logic               i_addr_down, i_x_fast;
  logic [ADDR_X-1:0]  i_addr_x_max;
  logic [ADDR_Y-1:0]  i_addr_y_max;
  logic [BG_DATA-1:0] i_bg_data;
  t_op_cmd            o_op_cmd;
  logic [ADDR_X-1:0]  o_addr_x;
  logic [ADDR_Y-1:0]  o_addr_y;
  logic [BG_DATA-1:0] o_data;
  logic               o_busy, o_done;

  typedef struct {
    logic [OPC_W-1:0]   num_ops;
    logic [ADDR_X-1:0]  x_max;
    logic [ADDR_Y-1:0]  y_max;
    logic               down;
    logic               x_fast;
    logic [BG_DATA-1:0] bg;
    t_op_cmd            ops [MAX_OPS];
    logic [MAX_OPS-1:0] inv;
  } cfg_t;

  typedef struct {
    cfg_t cfg;
    int   issues;
    int   fx, fy, lx, ly;
    int   done_cyc;
  } vec_t;

  typedef struct {
    t_op_cmd            op;
    int                 x;
    int                 y;
    logic [BG_DATA-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs [6];
  int   n_cmp = 0;
  int   n_err = 0;
  int   last_x = 0, last_y = 0;
  logic [BG_DATA-1:0] last_d = '0;

  march_elem_seq #(.MAX_OPS(MAX_OPS), .OPC_W(OPC_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_start      (i_start),
    .i_hold       (i_hold),
    .i_num_ops    (i_num_ops),
    .i_op_list    (i_op_list),
    .i_op_inv     (i_op_inv),
    .i_addr_down  (i_addr_down),
    .i_x_fast     (i_x_fast),
    .i_addr_x_max (i_addr_x_max),
    .i_addr_y_max (i_addr_y_max),
    .i_bg_data    (i_bg_data),
    .o_op_cmd     (o_op_cmd),
    .o_addr_x     (o_addr_x),
    .o_addr_y     (o_addr_y),
    .o_data       (o_data),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cfg_t mk_cfg(input int n, input int xm, input int ym, input bit down,
                                  input bit xf, input int bg, input t_op_cmd o0,
                                  input t_op_cmd o1, input t_op_cmd o2, input t_op_cmd o3,
                                  input logic [3:0] inv);
    cfg_t c;
    c.num_ops = OPC_W'(n);
    c.x_max   = ADDR_X'(xm);
    c.y_max   = ADDR_Y'(ym);
    c.down    = down;
    c.x_fast  = xf;
    c.bg      = BG_DATA'(bg);
    c.ops[0] = o0; c.ops[1] = o1; c.ops[2] = o2; c.ops[3] = o3;
    c.inv     = inv;
    return c;
  endfunction

  function automatic vec_t mk_vec(input cfg_t c, input int iss, input int fx, input int fy,
                                  input int lx, input int ly, input int dc);
    vec_t v;
    v.cfg = c; v.issues = iss; v.fx = fx; v.fy = fy; v.lx = lx; v.ly = ly; v.done_cyc = dc;
    return v;
  endfunction

  function automatic int eff_ops(input cfg_t c);
    int n = int'(c.num_ops);
    return (n == 0) ? 1 : ((n > MAX_OPS) ? MAX_OPS : n);
  endfunction

  // Reference: outer loop over the slow axis, inner over the fast axis,
  // then every op slot; descending mirrors each coordinate about its max.
  function automatic void build_model(input cfg_t c);
    int omax = c.x_fast ? int'(c.y_max) : int'(c.x_max);
    int imax = c.x_fast ? int'(c.x_max) : int'(c.y_max);
    exp_q.delete();
    for (int o = 0; o <= omax; o++)
      for (int i = 0; i <= imax; i++)
        for (int k = 0; k < eff_ops(c); k++) begin
          exp_t e;
          int xi = c.x_fast ? i : o;
          int yi = c.x_fast ? o : i;
          e.x  = c.down ? int'(c.x_max) - xi : xi;
          e.y  = c.down ? int'(c.y_max) - yi : yi;
          e.op = c.ops[k];
          e.d  = c.inv[k] ? ~c.bg : c.bg;
          exp_q.push_back(e);
        end
  endfunction

  task automatic apply_cfg(input cfg_t c);
    i_num_ops    = c.num_ops;
    i_addr_x_max = c.x_max;
    i_addr_y_max = c.y_max;
    i_addr_down  = c.down;
    i_x_fast     = c.x_fast;
    i_bg_data    = c.bg;
    i_op_inv     = c.inv;
    for (int k = 0; k < MAX_OPS; k++) i_op_list[k] = c.ops[k];
  endtask

  task automatic scramble_cfg();
    i_num_ops    = OPC_W'($urandom);
    i_addr_x_max = ADDR_X'($urandom);
    i_addr_y_max = ADDR_Y'($urandom);
    i_addr_down  = 1'($urandom);
    i_x_fast     = 1'($urandom);
    i_bg_data    = BG_DATA'($urandom);
    i_op_inv     = MAX_OPS'($urandom);
    for (int k = 0; k < MAX_OPS; k++) i_op_list[k] = t_op_cmd'($urandom_range(0, 3));
  endtask

  // Non-issuing cycle: NOP with address/data held at their last issued values.
  task automatic check_quiet(input string tag, input logic exp_done, input logic exp_busy);
    check({tag, "_op"},   o_op_cmd, OP_NOP);
    check({tag, "_x"},    o_addr_x, last_x);
    check({tag, "_y"},    o_addr_y, last_y);
    check({tag, "_data"}, o_data,   last_d);
    check({tag, "_done"}, o_done,   exp_done);
    check({tag, "_busy"}, o_busy,   exp_busy);
  endtask

  // hold_mode: 0 none, 1 random, 2 hold on cycles 5..7 after start.
  task automatic run_element(input cfg_t c, input int hold_mode, output int issued,
                             output int holds, output int done_cyc, output int fx,
                             output int fy, output int lx, output int ly);
    exp_t e;
    logic h;
    int   cyc = 0;
    int   budget;
    build_model(c);
    budget = exp_q.size() * 4 + 20;
    issued = 0; holds = 0; fx = -1; fy = -1; lx = -1; ly = -1;
    apply_cfg(c);
    i_start = 1'b1;
    i_hold  = 1'b0;
    @(posedge clk); #1;
    check_quiet("cyc0", 1'b0, 1'b0);
    i_start = 1'b0;
    scramble_cfg();
    while (exp_q.size() > 0 && cyc < budget) begin
      h = (hold_mode == 1) ? ($urandom_range(0, 3) == 0)
                           : (hold_mode == 2 && cyc + 1 >= 5 && cyc + 1 <= 7);
      i_hold  = h;
      i_start = ($urandom_range(0, 9) == 0);
      @(posedge clk); #1;
      cyc++;
      if (h) begin
        holds++;
        check_quiet("hold", 1'b0, 1'b1);
      end else begin
        e = exp_q.pop_front();
        check("issue_op",   o_op_cmd, e.op);
        check("issue_x",    o_addr_x, e.x);
        check("issue_y",    o_addr_y, e.y);
        check("issue_data", o_data,   e.d);
        check("issue_busy", o_busy,   1'b1);
        check("issue_done", o_done,   1'b0);
        if (issued == 0) begin fx = e.x; fy = e.y; end
        lx = e.x; ly = e.y;
        last_x = e.x; last_y = e.y; last_d = e.d;
        issued++;
      end
    end
    if (exp_q.size() > 0) check("issue_budget", exp_q.size(), 0);
    i_hold  = 1'($urandom);
    i_start = 1'b1;
    @(posedge clk); #1;
    cyc++;
    check_quiet("done", 1'b1, 1'b1);
    done_cyc = cyc;
    i_start = 1'b0;
    i_hold  = 1'b0;
  endtask

  initial begin
    int iss, hl, dc, fx, fy, lx, ly;
    cfg_t c;
    rstn    = 1'b0;
    i_start = 1'b0;
    i_hold  = 1'b0;
    apply_cfg(mk_cfg(0, 0, 0, 0, 0, 0, OP_NOP, OP_NOP, OP_NOP, OP_NOP, 4'h0));
    #12;
    check_quiet("reset", 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;

    vecs[0] = mk_vec(mk_cfg(2, 3, 3, 0, 1, 'h5A, OP_READ, OP_WRITE, OP_NOP, OP_NOP, 4'b0010),
                     32, 0, 0, 3, 3, 33);
    vecs[1] = mk_vec(mk_cfg(2, 3, 3, 1, 0, 'h5A, OP_READ, OP_WRITE, OP_NOP, OP_NOP, 4'b0010),
                     32, 3, 3, 0, 0, 33);
    vecs[2] = mk_vec(mk_cfg(0, 0, 0, 0, 1, 'hC3, OP_RMW, OP_WRITE, OP_READ, OP_READ, 4'b0001),
                     1, 0, 0, 0, 0, 2);
    vecs[3] = mk_vec(mk_cfg(4, 1, 0, 0, 1, 'h33, OP_WRITE, OP_WRITE, OP_WRITE, OP_WRITE, 4'b1010),
                     8, 0, 0, 1, 0, 9);
    vecs[4] = mk_vec(mk_cfg(7, 2, 1, 1, 1, 'h0F, OP_WRITE, OP_READ, OP_RMW, OP_READ, 4'b0110),
                     24, 2, 1, 0, 0, 25);
    vecs[5] = mk_vec(mk_cfg(1, 15, 0, 0, 0, 'hFF, OP_READ, OP_WRITE, OP_WRITE, OP_WRITE, 4'b0000),
                     16, 0, 0, 15, 0, 17);

    for (int v = 0; v < 6; v++) begin
      run_element(vecs[v].cfg, 0, iss, hl, dc, fx, fy, lx, ly);
      check($sformatf("vec%0d_issues", v), iss, vecs[v].issues);
      check($sformatf("vec%0d_first_x", v), fx, vecs[v].fx);
      check($sformatf("vec%0d_first_y", v), fy, vecs[v].fy);
      check($sformatf("vec%0d_last_x", v), lx, vecs[v].lx);
      check($sformatf("vec%0d_last_y", v), ly, vecs[v].ly);
      check($sformatf("vec%0d_done_cyc", v), dc, vecs[v].done_cyc);
    end

    run_element(vecs[0].cfg, 2, iss, hl, dc, fx, fy, lx, ly);
    check("hold_issues", iss, 32);
    check("hold_cycles", hl, 3);
    check("hold_done_cyc", dc, 36);

    // Abort a running element with reset at cycle 10.
    apply_cfg(vecs[0].cfg);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("pre_abort_busy", o_busy, 1'b1);
    rstn = 1'b0;
    #1;
    last_x = 0; last_y = 0; last_d = '0;
    check_quiet("abort", 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_done", o_done, 1'b0);
    end
    @(negedge clk) rstn = 1'b1;
    run_element(vecs[0].cfg, 0, iss, hl, dc, fx, fy, lx, ly);
    check("post_abort_issues", iss, 32);
    check("post_abort_done_cyc", dc, 33);

    for (int r = 0; r < 20; r++) begin
      c = mk_cfg($urandom_range(0, 7), $urandom_range(0, 5), $urandom_range(0, 3),
                 1'($urandom), 1'($urandom), $urandom_range(0, 255),
                 t_op_cmd'($urandom_range(1, 3)), t_op_cmd'($urandom_range(1, 3)),
                 t_op_cmd'($urandom_range(1, 3)), t_op_cmd'($urandom_range(1, 3)),
                 4'($urandom));
      run_element(c, 1, iss, hl, dc, fx, fy, lx, ly);
      check($sformatf("rnd%0d_issues", r), iss,
            eff_ops(c) * (int'(c.x_max) + 1) * (int'(c.y_max) + 1));
      check($sformatf("rnd%0d_done_cyc", r), dc, iss + hl + 1);
    end

    i_hold = 1'b1;
    @(posedge clk); #1;
    check_quiet("idle_end", 1'b0, 1'b0);
    i_hold = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/march_elem_seq.md
Name: march_elem_seq

Overview:
- Executes one march element for the PMBIST engine: walks the full address space and issues a programmed list of 1..MAX_OPS operations at each address.
- Sits directly upstream of ctrl_sigs_gen and mem_interface. Drives the op command, X/Y address and background data that those blocks decode and apply to the memory.
- A higher-level algorithm controller loads one element's configuration, pulses start, and waits for done.

Parameters:
- MAX_OPS, 4: maximum operations per address in one element.
- OPC_W, $clog2(MAX_OPS+1): width of the op-count input.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset; asynchronous, active-low.
- i_start  input  1  single-cycle start pulse; honoured only in IDLE.
- i_hold  input  1  pause: freezes counters and forces NOP output (used during result shift-out).
- i_num_ops  input  OPC_W  number of ops per address; 0 is treated as 1; values >MAX_OPS are clamped to MAX_OPS.
- i_op_list  input  MAX_OPS x t_op_cmd  op per slot; slot 0 is issued first.
- i_op_inv  input  MAX_OPS  per slot: 1 issues ~bg data, 0 issues bg data.
- i_addr_down  input  1  0 = ascending addresses, 1 = descending.
- i_x_fast  input  1  1 = X is the inner loop, 0 = Y is the inner loop.
- i_addr_x_max  input  ADDR_X  runtime X limit (≤ ADDR_X_MAX).
- i_addr_y_max  input  ADDR_Y  runtime Y limit (≤ ADDR_Y_MAX).
- i_bg_data  input  BG_DATA  background data pattern.
- o_op_cmd  output  t_op_cmd  registered op to ctrl_sigs_gen.
- o_addr_x  output  ADDR_X  registered X address.
- o_addr_y  output  ADDR_Y  registered Y address.
- o_data  output  BG_DATA  registered write/expect data.
- o_busy  output  1  element in progress.
- o_done  output  1  one-cycle completion pulse.

Behaviour:
- Reset values: o_op_cmd=NOP, o_addr_x=0, o_addr_y=0, o_data=0, o_busy=0, o_done=0; FSM in IDLE.
- Reset mid-element aborts immediately to these values. No done pulse is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when i_start=1.
  - RUN→DONE after the last op at the last address is issued.
  - DONE→IDLE unconditionally after one cycle.
- On the i_start edge:
  - All configuration inputs are latched.
  - Counters are preset. Ascending: x=0, y=0. Descending: x=i_addr_x_max, y=i_addr_y_max.
  - op_idx=0.
  - Configuration changes during RUN are ignored.
- Issue rule, in RUN with i_hold=0, at each edge:
  - Output registers load op_list[op_idx], the current x/y, and data = op_inv[op_idx] ? ~bg : bg.
  - op_idx increments. At num_ops-1, op_idx returns to 0 and the address steps.
- Latency: the first op appears on outputs the cycle after i_start is sampled. Ops are issued back to back, one per cycle.
- Address step:
  - The inner coordinate increments (or decrements when descending).
  - At its limit (max, or 0 when descending) the inner coordinate wraps to its start value and the outer coordinate steps.
- Last address: ascending (x_max, y_max); descending (0, 0). The element ends after op num_ops-1 at this address.
- i_hold=1 in RUN:
  - The next output op is NOP.
  - Addresses and data hold their last values.
  - Counters are frozen. Issue resumes exactly where it stopped.
  - Hold in IDLE or DONE has no effect.
- IDLE and DONE drive o_op_cmd=NOP; addr/data hold.
- Busy and done timing:
  - o_busy=1 from the first issue cycle through the DONE cycle.
  - o_done=1 only in the DONE cycle, which immediately follows the final issued op.
- i_start in RUN or DONE is ignored. i_start in the cycle after DONE (IDLE) starts a new element.
- Total issue cycles = num_ops × (x_max+1) × (y_max+1), excluding hold cycles.
- Degenerate case x_max=y_max=0: a single address, num_ops ops, then done.

Decomposition:
- pmbist package holds t_op_cmd, ADDR_X, ADDR_Y, ADDR_X_MAX, ADDR_Y_MAX and BG_DATA.
- Add a t_mes_state enum (IDLE, RUN, DONE) to the package.
- Sub-module addr_stepper holds the x/y counters, direction, fast-axis and wrap/last detection. It takes a step-enable and outputs x, y and is_last.

Test Plan:
- Config x_max=3, y_max=3, num_ops=2, ops {READ inv0, WRITE inv1}, ascending, x_fast, bg=0x5A; start at cycle 0:
  - Cycles 1..32 alternate READ/0x5A and WRITE/0xA5.
  - Addresses (0,0),(0,0),(1,0),(1,0)…(3,3).
  - o_done=1 at cycle 33, o_busy low at cycle 34.
- Same config, descending, y_fast: address order (3,3),(3,2),(3,1),(3,0),(2,3)…(0,0). Done after 32 issues.
- i_hold high for cycles 5..7 during the first test:
  - NOP on outputs for those 3 cycles; address/data held.
  - Sequence resumes with the op due at cycle 5. Done at cycle 36.
- num_ops=0 with x_max=y_max=0: one op (slot 0) at (0,0) at cycle 1, done at cycle 2. i_start re-pulsed at cycle 1 is ignored.
- rstn asserted at cycle 10 of a running element: all outputs are at reset values immediately, no o_done. A fresh start afterwards runs a full element.
- num_ops=4, all slots WRITE with inv {0,1,0,1}, x_max=1, y_max=0: 8 issues, data pattern bg,~bg,bg,~bg per address.
